// File: rtl/fc_layer_sequencer_if.sv
// AXI-Stream handshake bundle for the FC layer sequencer: input vector
// stream in, one result beat per neuron out.
interface fc_layer_sequencer_if;
  logic s_axis_tvalid;
  logic s_axis_tready;
  logic s_axis_tlast;
  logic m_axis_tvalid;
  logic m_axis_tready;
  logic m_axis_tlast;

  // Sequencer side: sinks the input stream, sources the result stream.
  modport slave (
    input  s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tlast
  );

  // Environment side: the mirror image.
  modport master (
    output s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/fc_layer_sequencer.sv
// FC layer sequencer: buffers one input vector, then walks every
// (neuron, input) pair driving buffer/weight addresses and MAC controls,
// waits out the MAC latency and emits one stream beat per neuron.
module fc_layer_sequencer #(
  parameter  int N_IN    = 16,
  parameter  int N_OUT   = 8,
  parameter  int ADDR_W  = 8,
  parameter  int MAC_LAT = 2,
  localparam int IN_AW   = $clog2(N_IN)
) (
  input  logic              S_AXIS_ACLK,
  input  logic              S_AXIS_ARESETN,
  fc_layer_sequencer_if.slave axis,
  output logic              buf_we,
  output logic [IN_AW-1:0]  buf_waddr,
  output logic [IN_AW-1:0]  buf_raddr,
  output logic [ADDR_W-1:0] w_addr,
  output logic              mac_en,
  output logic              acc_clr,
  output logic              busy,
  output logic              err
);
  localparam int OW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [IN_AW-1:0] IN_LAST = IN_AW'(N_IN - 1);
  localparam logic [OW-1:0]    O_LAST  = OW'(N_OUT - 1);
  localparam logic [DW-1:0]    D_LAST  = DW'(MAC_LAT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, CALC, DRAIN, OUT} state_t;

  state_t              state_q, state_d;
  logic [IN_AW-1:0]    in_cnt, i_cnt;
  logic [OW-1:0]       o_cnt;
  logic [DW-1:0]       drn_cnt;
  logic [ADDR_W-1:0]   w_addr_q;
  logic                err_q, err_d;
  logic                s_hs, in_last, i_last, o_last, d_last;

  assign axis.s_axis_tready = (state_q == IDLE) || (state_q == LOAD);
  assign s_hs    = axis.s_axis_tvalid & axis.s_axis_tready;
  assign in_last = (in_cnt == IN_LAST);
  assign i_last  = (i_cnt == IN_LAST);
  assign o_last  = (o_cnt == O_LAST);
  assign d_last  = (drn_cnt == D_LAST);

  // Buffer write is the only combinational path: it follows the handshake.
  assign buf_we    = s_hs;
  assign buf_waddr = in_cnt;
  assign buf_raddr = i_cnt;
  assign w_addr    = w_addr_q;
  assign mac_en    = (state_q == CALC);
  assign acc_clr   = (state_q == CALC) && (i_cnt == '0);
  assign axis.m_axis_tvalid = (state_q == OUT);
  assign axis.m_axis_tlast  = (state_q == OUT) && o_last;
  assign busy = (state_q != IDLE);
  assign err  = err_q;

  // State register.
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) state_q <= IDLE;
    else                 state_q <= state_d;
  end

  // Next-state and framing-error detection.
  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE, LOAD: begin
        if (s_hs) begin
          if (in_last) begin
            // Full vector: compute even if tlast is missing, but flag it.
            state_d = CALC;
            err_d   = ~axis.s_axis_tlast;
          end else if (axis.s_axis_tlast) begin
            // Short vector: drop it.
            state_d = IDLE;
            err_d   = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end
      end
      CALC:    if (i_last) state_d = DRAIN;
      DRAIN:   if (d_last) state_d = OUT;
      OUT:     if (axis.m_axis_tready) state_d = o_last ? IDLE : CALC;
      default: state_d = IDLE;
    endcase
  end

  // Counters; w_addr runs continuously across neurons (o*N_IN+i) and
  // parks on its final value until the layer handshake clears it.
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      in_cnt   <= '0;
      i_cnt    <= '0;
      o_cnt    <= '0;
      drn_cnt  <= '0;
      w_addr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= err_d;
      if (s_hs)
        in_cnt <= (in_last || axis.s_axis_tlast) ? '0 : in_cnt + 1'b1;
      if (state_q == CALC)
        i_cnt <= i_last ? '0 : i_cnt + 1'b1;
      drn_cnt <= ((state_q == DRAIN) && !d_last) ? drn_cnt + 1'b1 : '0;
      if (s_hs && in_last)
        w_addr_q <= '0;
      else if ((state_q == CALC) && !(i_last && o_last))
        w_addr_q <= w_addr_q + 1'b1;
      else if ((state_q == OUT) && axis.m_axis_tready && o_last)
        w_addr_q <= '0;
      if ((state_q == OUT) && axis.m_axis_tready)
        o_cnt <= o_last ? '0 : o_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Scoreboard bench for fc_layer_sequencer: the driver pushes expected
// buffer writes, MAC steps, result beats and error pulses derived from the
// layer arithmetic; a negedge monitor pops and compares as the DUT acts.
module tb_fc_layer_sequencer;
  localparam int N_IN = 16, N_OUT = 8, ADDR_W = 8, MAC_LAT = 2, IN_AW = 4;
  localparam int NEURON_CYC = N_IN + MAC_LAT + 1;

  logic S_AXIS_ACLK = 1'b0;
  logic S_AXIS_ARESETN = 1'b0;
  logic buf_we, mac_en, acc_clr, busy, err;
  logic [IN_AW-1:0]  buf_waddr, buf_raddr;
  logic [ADDR_W-1:0] w_addr;

  fc_layer_sequencer_if ifc ();

  fc_layer_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .ADDR_W(ADDR_W), .MAC_LAT(MAC_LAT)) dut (
    .S_AXIS_ACLK(S_AXIS_ACLK), .S_AXIS_ARESETN(S_AXIS_ARESETN), .axis(ifc),
    .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_raddr(buf_raddr), .w_addr(w_addr),
    .mac_en(mac_en), .acc_clr(acc_clr), .busy(busy), .err(err)
  );

  always #5 S_AXIS_ACLK = ~S_AXIS_ACLK;

  int cyc = 0;
  always @(posedge S_AXIS_ACLK) cyc <= cyc + 1;

  typedef struct { int a; int b; int c; int cyc; } exp_t;
  exp_t q_wr[$], q_mac[$], q_out[$], q_err[$];
  int  n_chk = 0, n_fail = 0;
  bit  rdy_rand = 1'b0;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  task automatic flush();
    q_wr.delete(); q_mac.delete(); q_out.delete(); q_err.delete();
  endtask

  // Downstream ready: always high, or sparse random to exercise holds.
  initial begin
    ifc.m_axis_tready = 1'b1;
    forever begin
      @(posedge S_AXIS_ACLK); #1;
      ifc.m_axis_tready = rdy_rand ? ($urandom_range(0, 9) < 3) : 1'b1;
    end
  end

  // Monitor.
  logic p_v = 1'b0, p_r = 1'b0, p_l = 1'b0;
  logic [ADDR_W-1:0] p_w = '0;
  always @(negedge S_AXIS_ACLK) begin
    exp_t e;
    if (!S_AXIS_ARESETN) begin
      p_v <= 1'b0; p_r <= 1'b0; p_l <= 1'b0; p_w <= '0;
    end else begin
      if (p_v && !p_r) begin
        chk("out_hold_valid", int'(ifc.m_axis_tvalid), 1);
        chk("out_hold_last", int'(ifc.m_axis_tlast), int'(p_l));
        chk("out_hold_no_mac", int'(mac_en), 0);
        chk("out_hold_waddr", int'(w_addr), int'(p_w));
      end
      if (buf_we) begin
        if (q_wr.size() == 0) fail_now("unexpected_buf_we");
        else begin
          e = q_wr.pop_front();
          chk("buf_waddr", int'(buf_waddr), e.a);
          chk("write_cycle", cyc, e.cyc);
        end
      end
      if (mac_en) begin
        if (q_mac.size() == 0) fail_now("unexpected_mac_en");
        else begin
          e = q_mac.pop_front();
          chk("w_addr", int'(w_addr), e.a);
          chk("buf_raddr", int'(buf_raddr), e.b);
          chk("acc_clr", int'(acc_clr), e.c);
          chk("calc_tready", int'(ifc.s_axis_tready), 0);
          if (e.cyc >= 0) chk("mac_cycle", cyc, e.cyc);
        end
      end else if (acc_clr) fail_now("acc_clr_without_mac");
      if (ifc.m_axis_tvalid && ifc.m_axis_tready) begin
        if (q_out.size() == 0) fail_now("unexpected_m_axis_beat");
        else begin
          e = q_out.pop_front();
          chk("m_axis_tlast", int'(ifc.m_axis_tlast), e.a);
          if (e.cyc >= 0) chk("m_axis_cycle", cyc, e.cyc);
        end
      end
      if (err) begin
        if (q_err.size() == 0) fail_now("unexpected_err");
        else begin
          e = q_err.pop_front();
          chk("err_cycle", cyc, e.cyc);
        end
      end
      p_v <= ifc.m_axis_tvalid; p_r <= ifc.m_axis_tready;
      p_l <= ifc.m_axis_tlast;  p_w <= w_addr;
    end
  end

  // Drive nbeats beats, tlast on beat last_pos (-1: never); push the
  // expected consequences of the vector from the layer arithmetic.
  task automatic send_vec(int nbeats, int last_pos, bit gaps);
    int t_last = 0;
    for (int b = 0; b < nbeats; b++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge S_AXIS_ACLK); #1;
          ifc.s_axis_tvalid = 1'b0;
          ifc.s_axis_tlast  = 1'b0;
        end
      end
      @(posedge S_AXIS_ACLK); #1;
      ifc.s_axis_tvalid = 1'b1;
      ifc.s_axis_tlast  = (b == last_pos);
      q_wr.push_back('{b, 0, 0, cyc});
      t_last = cyc;
    end
    if (nbeats < N_IN) begin
      q_err.push_back('{0, 0, 0, t_last + 1});
    end else begin
      if (last_pos != N_IN - 1) q_err.push_back('{0, 0, 0, t_last + 1});
      for (int o = 0; o < N_OUT; o++) begin
        for (int i = 0; i < N_IN; i++)
          q_mac.push_back('{o * N_IN + i, i, int'(i == 0),
                            (!rdy_rand || o == 0) ? t_last + 1 + o * NEURON_CYC + i : -1});
        q_out.push_back('{int'(o == N_OUT - 1), 0, 0,
                          rdy_rand ? -1 : t_last + NEURON_CYC + o * NEURON_CYC});
      end
    end
    @(posedge S_AXIS_ACLK); #1;
    ifc.s_axis_tvalid = 1'b0;
    ifc.s_axis_tlast  = 1'b0;
  endtask

  // Wait for every expected event to be consumed, then check the block is idle.
  task automatic wait_idle(string nm);
    int n = 0;
    while ((q_wr.size() + q_mac.size() + q_out.size() + q_err.size()) != 0 && n < 3000) begin
      @(negedge S_AXIS_ACLK);
      n++;
    end
    if (n >= 3000) begin
      fail_now({nm, "_timeout"});
      flush();
    end
    @(negedge S_AXIS_ACLK);
    chk({nm, "_busy_low"}, int'(busy), 0);
    chk({nm, "_s_tready_high"}, int'(ifc.s_axis_tready), 1);
  endtask

  task automatic check_reset_outputs(string nm);
    chk({nm, "_s_tready"}, int'(ifc.s_axis_tready), 1);
    chk({nm, "_buf_we"}, int'(buf_we), 0);
    chk({nm, "_buf_waddr"}, int'(buf_waddr), 0);
    chk({nm, "_buf_raddr"}, int'(buf_raddr), 0);
    chk({nm, "_w_addr"}, int'(w_addr), 0);
    chk({nm, "_mac_en"}, int'(mac_en), 0);
    chk({nm, "_acc_clr"}, int'(acc_clr), 0);
    chk({nm, "_m_tvalid"}, int'(ifc.m_axis_tvalid), 0);
    chk({nm, "_m_tlast"}, int'(ifc.m_axis_tlast), 0);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_err"}, int'(err), 0);
  endtask

  initial begin
    int n;
    ifc.s_axis_tvalid = 1'b0;
    ifc.s_axis_tlast  = 1'b0;
    #3;
    check_reset_outputs("reset");
    @(negedge S_AXIS_ACLK);
    @(posedge S_AXIS_ACLK); #2;
    S_AXIS_ARESETN = 1'b1;

    // Clean vector, downstream always ready: exact latencies.
    rdy_rand = 1'b0;
    send_vec(N_IN, N_IN - 1, 1'b0);
    wait_idle("clean");

    // Backpressure on the result stream with input gaps.
    rdy_rand = 1'b1;
    send_vec(N_IN, N_IN - 1, 1'b1);
    wait_idle("backpressure");
    rdy_rand = 1'b0;

    // Early tlast on beat 5, then a clean vector.
    send_vec(5, 4, 1'b0);
    wait_idle("short");
    send_vec(N_IN, N_IN - 1, 1'b0);
    wait_idle("after_short");

    // Missing tlast on the 16th beat, with gaps.
    send_vec(N_IN, -1, 1'b1);
    wait_idle("no_tlast");

    // Random mix.
    for (int v = 0; v < 5; v++) begin
      int kind = $urandom_range(0, 3);
      rdy_rand = (kind == 1);
      case (kind)
        0, 1: send_vec(N_IN, N_IN - 1, $urandom_range(0, 1) == 1);
        2: begin
          int p = $urandom_range(0, N_IN - 2);
          send_vec(p + 1, p, 1'b1);
        end
        default: send_vec(N_IN, -1, 1'b0);
      endcase
      wait_idle("random");
      rdy_rand = 1'b0;
    end

    // Reset mid-CALC of neuron 3.
    send_vec(N_IN, N_IN - 1, 1'b0);
    n = 0;
    while (q_out.size() > N_OUT - 3 && n < 1000) begin
      @(negedge S_AXIS_ACLK);
      n++;
    end
    if (n >= 1000) fail_now("reset_wait_timeout");
    repeat (6) @(negedge S_AXIS_ACLK);
    chk("pre_reset_calc", int'(mac_en), 1);
    @(posedge S_AXIS_ACLK); #2;
    S_AXIS_ARESETN = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    flush();
    repeat (2) @(negedge S_AXIS_ACLK);
    @(posedge S_AXIS_ACLK); #2;
    S_AXIS_ARESETN = 1'b1;
    send_vec(N_IN, N_IN - 1, 1'b0);
    wait_idle("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end
endmodule
